// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory access size encodings, MEM-stage FSM states
// and the store-lane / alignment helpers used by the MEM stage.
package cpu_pkg;

   localparam int XLEN    = 32;
   localparam int RADDR_W = 5;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } mem_size_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } mem_state_e;

   // Size code 3 falls into the default arm and behaves as a word.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
      case (size)
         SZ_BYTE: is_misaligned = 1'b0;
         SZ_HALF: is_misaligned = addr[0];
         default: is_misaligned = (addr != 2'b00);
      endcase
   endfunction

   function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] addr);
      case (size)
         SZ_BYTE: store_be = 4'b0001 << addr;
         SZ_HALF: store_be = addr[1] ? 4'b1100 : 4'b0011;
         default: store_be = 4'b1111;
      endcase
   endfunction

   // Replicating the datum across lanes lets byte enables alone select the target.
   function automatic logic [XLEN-1:0] store_wdata(input logic [1:0] size,
                                                   input logic [XLEN-1:0] data);
      case (size)
         SZ_BYTE: store_wdata = {4{data[7:0]}};
         SZ_HALF: store_wdata = {2{data[15:0]}};
         default: store_wdata = data;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load alignment: shifts the addressed lane of a little-endian memory word down
// to bit 0, truncates to the access size and sign- or zero-extends it.
module load_align
   import cpu_pkg::*;
(
   input  logic [XLEN-1:0] rdata_i,
   input  logic [1:0]      addr_i,
   input  logic [1:0]      size_i,
   input  logic            signed_i,
   output logic [XLEN-1:0] data_o
);

   logic        [XLEN-1:0] shifted;
   logic signed [7:0]      byte_s;
   logic signed [15:0]     half_s;
   logic signed [XLEN-1:0] byte_ext;
   logic signed [XLEN-1:0] half_ext;

   assign shifted  = rdata_i >> {addr_i, 3'b000};
   assign byte_s   = shifted[7:0];
   assign half_s   = shifted[15:0];
   assign byte_ext = XLEN'(byte_s);
   assign half_ext = XLEN'(half_s);

   always_comb begin
      data_o = shifted;
      case (size_i)
         SZ_BYTE: data_o = signed_i ? byte_ext : {24'b0, shifted[7:0]};
         SZ_HALF: data_o = signed_i ? half_ext : {16'b0, shifted[15:0]};
         default: data_o = shifted;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: EX/MEM and MEM/WB pipeline registers, single-port data-memory
// req/ack handshake, and byte/half/word load/store alignment.
module mem_access_stage
   import cpu_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [XLEN-1:0]    alu_outE,
   input  logic [XLEN-1:0]    r2_doutEC,
   input  logic [RADDR_W-1:0] r3_addrE,
   input  logic               RegWriteE,
   input  logic               MemtoRegE,
   input  logic               MemWriteE,
   input  logic [1:0]         mem_sizeE,
   input  logic               mem_signedE,
   input  logic               trapE,
   input  logic               flushM,
   output logic [XLEN-1:0]    alu_outM,
   output logic [RADDR_W-1:0] r3_addrM,
   output logic               RegWriteM,
   output logic               MemtoRegM,
   output logic [XLEN-1:0]    alu_outW,
   output logic [XLEN-1:0]    read_dataW,
   output logic [RADDR_W-1:0] r3_addrW,
   output logic               RegWriteW,
   output logic               MemtoRegW,
   output logic [XLEN-1:0]    r3_dinW,
   output logic               stallM,
   output logic               misalignM,
   output logic               dmem_req,
   output logic               dmem_we,
   output logic [XLEN-1:0]    dmem_addr,
   output logic [3:0]         dmem_be,
   output logic [XLEN-1:0]    dmem_wdata,
   input  logic               dmem_ack,
   input  logic [XLEN-1:0]    dmem_rdata
);

   logic [XLEN-1:0]    alu_m_q;
   logic [XLEN-1:0]    sdata_m_q;
   logic [RADDR_W-1:0] r3_m_q;
   logic               rw_m_q;
   logic               m2r_m_q;
   logic               mw_m_q;
   logic [1:0]         size_m_q;
   logic               sgn_m_q;

   logic [XLEN-1:0]    alu_w_q;
   logic [XLEN-1:0]    rdata_w_q;
   logic [RADDR_W-1:0] r3_w_q;
   logic               rw_w_q;
   logic               m2r_w_q;

   mem_state_e         state_q;
   mem_state_e         state_d;

   logic               mem_op;
   logic [XLEN-1:0]    load_val;

   // ---- EX/MEM register ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alu_m_q   <= '0;
         sdata_m_q <= '0;
         r3_m_q    <= '0;
         rw_m_q    <= 1'b0;
         m2r_m_q   <= 1'b0;
         mw_m_q    <= 1'b0;
         size_m_q  <= 2'b00;
         sgn_m_q   <= 1'b0;
      end else if (!stallM) begin
         alu_m_q   <= alu_outE;
         sdata_m_q <= r2_doutEC;
         r3_m_q    <= r3_addrE;
         size_m_q  <= mem_sizeE;
         sgn_m_q   <= mem_signedE;
         if (trapE || flushM) begin
            rw_m_q  <= 1'b0;
            m2r_m_q <= 1'b0;
            mw_m_q  <= 1'b0;
         end else begin
            rw_m_q  <= RegWriteE;
            m2r_m_q <= MemtoRegE;
            mw_m_q  <= MemWriteE;
         end
      end
   end

   assign alu_outM  = alu_m_q;
   assign r3_addrM  = r3_m_q;
   assign RegWriteM = rw_m_q;
   assign MemtoRegM = m2r_m_q;

   // ---- M stage: bus drive and handshake ----
   assign mem_op    = m2r_m_q | mw_m_q;
   assign misalignM = mem_op & is_misaligned(size_m_q, alu_m_q[1:0]);
   // Gating with rst_n drops the request in the very cycle reset is asserted.
   assign dmem_req  = rst_n & mem_op & ~misalignM;
   assign stallM    = dmem_req & ~dmem_ack;

   // Bus fields come straight from the held EX/MEM register, so they stay stable in WAIT.
   assign dmem_we    = dmem_req & mw_m_q;
   assign dmem_addr  = {alu_m_q[XLEN-1:2], 2'b00};
   assign dmem_be    = mw_m_q ? store_be(size_m_q, alu_m_q[1:0]) : 4'b1111;
   assign dmem_wdata = store_wdata(size_m_q, sdata_m_q);

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (dmem_req && !dmem_ack) state_d = S_WAIT;
         S_WAIT:  if (dmem_ack || !dmem_req) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   load_align u_load_align (
      .rdata_i  (dmem_rdata),
      .addr_i   (alu_m_q[1:0]),
      .size_i   (size_m_q),
      .signed_i (sgn_m_q),
      .data_o   (load_val)
   );

   // ---- MEM/WB register ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alu_w_q   <= '0;
         rdata_w_q <= '0;
         r3_w_q    <= '0;
         rw_w_q    <= 1'b0;
         m2r_w_q   <= 1'b0;
      end else begin
         alu_w_q   <= alu_m_q;
         rdata_w_q <= m2r_m_q ? load_val : '0;
         r3_w_q    <= r3_m_q;
         if (stallM || misalignM) begin
            rw_w_q  <= 1'b0;
            m2r_w_q <= 1'b0;
         end else begin
            rw_w_q  <= rw_m_q;
            m2r_w_q <= m2r_m_q;
         end
      end
   end

   assign alu_outW   = alu_w_q;
   assign read_dataW = rdata_w_q;
   assign r3_addrW   = r3_w_q;
   assign RegWriteW  = rw_w_q;
   assign MemtoRegW  = m2r_w_q;
   assign r3_dinW    = m2r_w_q ? rdata_w_q : alu_w_q;

endmodule
